bcd_scan_counter: RTL

Parametrised multi-digit BCD up/down counter with an internal tick prescaler and a time-multiplexed seven-segment driver. It is the next generation of the single-digit decade counter: N digits, direction control, load/clear, a terminal-count pulse and leading-zero blanking. It sits between the board clock and the seven-segment/anode pins and needs no external logic.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 30 +++
 rtl/bcd_scan_counter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the BCD digit type.
// Patterns are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high seven-segment pattern.
// Codes above 9 and the blank request both give a dark digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with tick prescaler, terminal-count pulse
// and a multiplexed seven-segment driver with leading-zero blanking.
module bcd_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 100_000_000,
    parameter int SCAN_DIV       = 100_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam logic [DIGITS-1:0] AN_FIRST  = DIGITS'(1);
    localparam logic [DIGITS-1:0] AN_RESET  = AN_ACTIVE_LOW  ? ~AN_FIRST : AN_FIRST;
    localparam logic [6:0]        SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_0    : SEG_0;

    logic [PRE_W-1:0]    pre;
    logic                tick;
    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_sat;
    logic                chain_carry;
    logic                wrap;
    logic                tc_q;

    logic [SCAN_W-1:0]   scan_div;
    logic [IDX_W-1:0]    idx;
    bcd_t                cur_digit;
    logic                cur_blank;
    logic                above_zero;
    logic [DIGITS-1:0]   an_sel;
    logic [6:0]          pattern;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;

    assign tick = en && (pre == PRE_LAST);

    // Ripple chain: carry (up) or borrow (down) passes on while digits roll over.
    always_comb begin
        step_val    = count_q;
        chain_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (chain_carry) begin
                if (up) begin
                    if (count_q[4*k +: 4] == 4'd9) begin
                        step_val[4*k +: 4] = 4'd0;
                    end else begin
                        step_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                        chain_carry        = 1'b0;
                    end
                end else begin
                    if (count_q[4*k +: 4] == 4'd0) begin
                        step_val[4*k +: 4] = 4'd9;
                    end else begin
                        step_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                        chain_carry        = 1'b0;
                    end
                end
            end
        end
        wrap = chain_carry;
    end

    always_comb begin
        load_sat = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_sat[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pre     <= '0;
            tc_q    <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            pre     <= '0;
            tc_q    <= 1'b0;
        end else if (load) begin
            count_q <= load_sat;
            pre     <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= tick && wrap;
            if (tick) begin
                count_q <= step_val;
            end
            if (en) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_div <= '0;
            idx      <= '0;
        end else if (scan_div == SCAN_LAST) begin
            scan_div <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            scan_div <= scan_div + SCAN_W'(1);
        end
    end

    // Walk from the top digit down so above_zero means "this and all higher digits are 0".
    always_comb begin
        cur_digit  = '0;
        cur_blank  = 1'b0;
        an_sel     = '0;
        above_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above_zero = above_zero && (count_q[4*k +: 4] == 4'd0);
            if (int'(idx) == k) begin
                cur_digit = count_q[4*k +: 4];
                cur_blank = blank_lz && (k != 0) && above_zero;
                an_sel[k] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .digit   (cur_digit),
        .blank   (cur_blank),
        .pattern (pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_RESET;
            an_q  <= AN_RESET;
        end else begin
            seg_q <= SEG_ACTIVE_LOW ? ~pattern : pattern;
            an_q  <= AN_ACTIVE_LOW  ? ~an_sel  : an_sel;
        end
    end

    assign count_bcd = count_q;
    assign tc        = tc_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
